// File: rtl/cpu_clk_ctrl.sv
// CPU execution-rate sequencer: emits single-cycle clock-enable pulses for fast run,
// slow run, single step and CPU-requested halt, and counts the pulses it issues.
module cpu_clk_ctrl #(
  parameter int FAST_DIV  = 4,
  parameter int SLOW_DIV  = 33554432,
  parameter int DB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sw_slow,
  input  logic        sw_step,
  input  logic        btn_step,
  input  logic        halt_req,
  output logic        cpu_ce,
  output logic [31:0] cycle_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STEP_IDLE = 2'd1,
    STEP_FIRE = 2'd2,
    HALT      = 2'd3
  } state_e;

  localparam logic [31:0] FAST_LAST = 32'(FAST_DIV - 1);
  localparam logic [31:0] SLOW_LAST = 32'(SLOW_DIV - 1);
  localparam logic [31:0] DB_LAST   = 32'(DB_CYCLES - 1);

  // Bit 0 is the metastability catcher, bit 1 the usable synchronized level.
  logic [1:0]  slow_sync_q, step_sync_q, btn_sync_q;
  logic        slow_prev_q;
  logic        btn_db_q, btn_db_prev_q;
  logic [31:0] db_cnt_q;
  logic [31:0] div_cnt_q, div_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        ce_q, ce_d;
  state_e      state_q, state_d;

  logic        slow_s, step_s, press;
  logic [31:0] div_last;

  assign slow_s   = slow_sync_q[1];
  assign step_s   = step_sync_q[1];
  assign press    = btn_db_q & ~btn_db_prev_q;
  assign div_last = slow_s ? SLOW_LAST : FAST_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_sync_q   <= 2'b00;
      step_sync_q   <= 2'b00;
      btn_sync_q    <= 2'b00;
      slow_prev_q   <= 1'b0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      db_cnt_q      <= 32'd0;
    end else begin
      slow_sync_q   <= {slow_sync_q[0], sw_slow};
      step_sync_q   <= {step_sync_q[0], sw_step};
      btn_sync_q    <= {btn_sync_q[0], btn_step};
      slow_prev_q   <= slow_s;
      btn_db_prev_q <= btn_db_q;
      // Any agreement between raw and debounced level restarts the stability window.
      if (btn_sync_q[1] != btn_db_q) begin
        if (db_cnt_q == DB_LAST) begin
          btn_db_q <= btn_sync_q[1];
          db_cnt_q <= 32'd0;
        end else begin
          db_cnt_q <= db_cnt_q + 32'd1;
        end
      end else begin
        db_cnt_q <= 32'd0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = 32'd0;
    ce_d      = 1'b0;
    if (halt_req) begin
      state_d = HALT;
    end else begin
      unique case (state_q)
        RUN: begin
          if (step_s) begin
            state_d = STEP_IDLE;
          end else if (slow_s != slow_prev_q) begin
            div_cnt_d = 32'd0;
          end else if (div_cnt_q == div_last) begin
            ce_d      = 1'b1;
            div_cnt_d = 32'd0;
          end else begin
            div_cnt_d = div_cnt_q + 32'd1;
          end
        end
        STEP_IDLE: begin
          if (!step_s) begin
            state_d = RUN;
          end else if (press) begin
            state_d = STEP_FIRE;
            ce_d    = 1'b1;
          end
        end
        STEP_FIRE: state_d = STEP_IDLE;
        HALT: begin
          if (press) state_d = step_s ? STEP_IDLE : RUN;
        end
        default: state_d = RUN;
      endcase
    end
    cycle_cnt_d = cycle_cnt_q + {31'd0, ce_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      div_cnt_q   <= 32'd0;
      ce_q        <= 1'b0;
      cycle_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      ce_q        <= ce_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cpu_ce    = ce_q;
  assign cycle_cnt = cycle_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: randomized and directed stimulus compared every cycle
// against a rule-level model, plus literal latency/period/wrap expectations.
module tb_cpu_clk_ctrl;

  localparam int FAST = 4;
  localparam int SLOW = 16;
  localparam int DB   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw_slow, sw_step, btn_step, halt_req;
  logic        cpu_ce;
  logic [31:0] cycle_cnt;
  logic [1:0]  state;

  int n_pass = 0;
  int n_tot  = 0;
  logic preload = 1'b0;

  cpu_clk_ctrl #(.FAST_DIV(FAST), .SLOW_DIV(SLOW), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sw_slow(sw_slow), .sw_step(sw_step),
    .btn_step(btn_step), .halt_req(halt_req), .cpu_ce(cpu_ce),
    .cycle_cnt(cycle_cnt), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: pin histories give the synchronized levels, the button is
  // accepted after DB consecutive disagreeing cycles, and a RUN pulse falls on
  // every DIV-th cycle counted from the last restart of the run.
  logic [1:0]  slow_h, step_h, btn_h;
  logic        m_db, m_dbprev, m_slow_prev, m_ce;
  int          m_run, m_el, m_state;
  logic [31:0] m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_h <= 2'b00; step_h <= 2'b00; btn_h <= 2'b00;
      m_db <= 1'b0; m_dbprev <= 1'b0; m_slow_prev <= 1'b0; m_ce <= 1'b0;
      m_run <= 0; m_el <= 0; m_state <= 0; m_cnt <= 32'd0;
    end else begin : upd
      logic sl, st, b, pr, ce, db_n;
      int ns, dv, el, run_n;
      sl = slow_h[1]; st = step_h[1]; b = btn_h[1];
      db_n = m_db; run_n = 0;
      if (b != m_db) begin
        run_n = m_run + 1;
        if (run_n == DB) begin db_n = b; run_n = 0; end
      end
      pr = m_db && !m_dbprev;
      dv = sl ? SLOW : FAST;
      ns = m_state; ce = 1'b0; el = 0;
      if (halt_req) ns = 3;
      else case (m_state)
        0: if (st) ns = 1;
           else if (sl != m_slow_prev) el = 0;
           else begin ce = ((m_el + 1) % dv) == 0; el = m_el + 1; end
        1: if (!st) ns = 0; else if (pr) begin ns = 2; ce = 1'b1; end
        2: ns = 1;
        default: if (pr) ns = st ? 1 : 0;
      endcase
      slow_h <= {slow_h[0], sw_slow};
      step_h <= {step_h[0], sw_step};
      btn_h  <= {btn_h[0], btn_step};
      m_dbprev <= m_db; m_db <= db_n; m_run <= run_n;
      m_slow_prev <= sl; m_el <= el; m_state <= ns; m_ce <= ce;
      m_cnt <= (preload ? 32'hFFFF_FFFE : m_cnt) + {31'd0, ce};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      chk("model_state", {30'd0, state}, 32'(m_state));
      chk("model_cpu_ce", {31'd0, cpu_ce}, {31'd0, m_ce});
      chk("model_cycle_cnt", cycle_cnt, m_cnt);
    end
  endtask

  task automatic wait_pulse(input int max, input string name, output int gap);
    gap = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (cpu_ce) begin gap = i; break; end
    end
    if (gap < 0) chk({name, "_timeout"}, 32'hFFFF_FFFF, 32'(max));
  endtask

  task automatic wait_state(input int target, input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      if (state == 2'(target)) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk("wait_state_timeout", {30'd0, state}, 32'(target));
  endtask

  // Holds the button for 'hold' cycles inside a 'win'-cycle window, reporting pulses.
  task automatic press(input int hold, input int win, output int first, output int npulse,
                       output int st_at, output int st_after);
    first = -1; npulse = 0; st_at = -1; st_after = -1;
    btn_step = 1'b1;
    for (int i = 1; i <= win; i++) begin
      tick();
      if (first > 0 && st_after < 0) st_after = int'(state);
      if (cpu_ce) begin
        npulse++;
        if (first < 0) begin first = i; st_at = int'(state); end
      end
      if (i == hold) btn_step = 1'b0;
    end
  endtask

  initial begin
    int g, f, np, sa, sf;
    logic [31:0] c0;
    rst_n = 1'b0; sw_slow = 1'b0; sw_step = 1'b0; btn_step = 1'b0; halt_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_cpu_ce", {31'd0, cpu_ce}, 32'd0);
    chk("reset_cycle_cnt", cycle_cnt, 32'd0);

    // Fast run straight out of reset.
    rst_n = 1'b1;
    wait_pulse(20, "first_pulse", g);
    chk("first_pulse_latency", 32'(g), 32'd4);
    for (int k = 0; k < 9; k++) begin
      wait_pulse(20, "fast_pulse", g);
      chk("fast_period", 32'(g), 32'd4);
    end
    chk("cnt_after_10", cycle_cnt, 32'd10);

    sw_slow = 1'b1;
    wait_pulse(40, "slow_pulse", g);
    wait_pulse(40, "slow_pulse", g);
    chk("slow_period", 32'(g), 32'd16);
    wait_pulse(40, "slow_pulse", g);
    chk("slow_period2", 32'(g), 32'd16);
    sw_slow = 1'b0;

    // Single step with a clean press.
    sw_step = 1'b1;
    repeat (4) tick();
    chk("step_idle", {30'd0, state}, 32'd1);
    c0 = cycle_cnt;
    press(10, 20, f, np, sa, sf);
    chk("step_latency", 32'(f), 32'd7);
    chk("step_pulses", 32'(np), 32'd1);
    chk("step_state_fire", 32'(sa), 32'd2);
    chk("step_state_after", 32'(sf), 32'd1);
    chk("step_cnt_inc", cycle_cnt, c0 + 32'd1);
    press(10, 20, f, np, sa, sf);
    chk("step2_pulses", 32'(np), 32'd1);

    // Bouncy press: toggles every 2 clocks, then held high.
    np = 0;
    for (int i = 0; i < 12; i++) begin
      btn_step = ((i / 2) % 2) == 0;
      tick();
      if (cpu_ce) np++;
    end
    chk("bounce_no_pulse", 32'(np), 32'd0);
    press(20, 30, f, np, sa, sf);
    chk("bounce_pulses", 32'(np), 32'd1);

    // Halt landing on the cycle that would have pulsed.
    sw_step = 1'b0;
    wait_state(0, 20);
    for (int i = 0; i < 40 && !(m_state == 0 && (m_el % FAST) == FAST - 1); i++) tick();
    halt_req = 1'b1;
    tick();
    chk("halt_no_pulse", {31'd0, cpu_ce}, 32'd0);
    chk("halt_state", {30'd0, state}, 32'd3);
    press(10, 20, f, np, sa, sf);
    chk("halt_press_ignored", {30'd0, state}, 32'd3);
    chk("halt_press_no_pulse", 32'(np), 32'd0);
    halt_req = 1'b0;
    tick();
    btn_step = 1'b1;
    wait_state(0, 20);
    wait_pulse(20, "resume_pulse", g);
    chk("resume_latency", 32'(g), 32'd4);
    btn_step = 1'b0;

    // Counter wrap from a preloaded value.
    sw_step = 1'b1;
    wait_state(1, 20);
    repeat (10) tick();
    #2 force dut.cycle_cnt_q = 32'hFFFF_FFFE;
    preload = 1'b1;
    #1 release dut.cycle_cnt_q;
    @(posedge clk);
    #1 preload = 1'b0;
    press(10, 20, f, np, sa, sf);
    chk("wrap_ffffffff", m_cnt, 32'hFFFF_FFFF);
    chk("wrap_dut_ffffffff", cycle_cnt, 32'hFFFF_FFFF);
    press(10, 20, f, np, sa, sf);
    chk("wrap_zero", cycle_cnt, 32'd0);

    // Randomized mix of all inputs.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0: sw_slow = ~sw_slow;
        1: sw_step = ~sw_step;
        2: halt_req = ($urandom_range(0, 3) == 0);
        default: btn_step = 1'($urandom_range(0, 1));
      endcase
      repeat ($urandom_range(1, 12)) tick();
    end

    // Reset asserted while the step pulse is on.
    halt_req = 1'b0; btn_step = 1'b0; sw_step = 1'b1;
    repeat (12) tick();
    wait_state(1, 20);
    btn_step = 1'b1;
    wait_state(2, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_cpu_ce", {31'd0, cpu_ce}, 32'd0);
    chk("midreset_state", {30'd0, state}, 32'd0);
    chk("midreset_cnt", cycle_cnt, 32'd0);
    tick();
    btn_step = 1'b0;
    rst_n = 1'b1;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Sequences the CPU's execution rate on the board without generating derived clocks.
- Produces a single-cycle clock-enable pulse `cpu_ce` on the system clock, so the CPU core and its pipeline registers advance only when `cpu_ce` is high.
- Supports fast free-run, slow free-run, button-driven single step, and a halt requested by the CPU. A retired-cycle counter is provided for board display.

Parameters:
- FAST_DIV, 4, system clocks per cpu_ce pulse in fast run mode (>=1).
- SLOW_DIV, 33554432, system clocks per cpu_ce pulse in slow run mode (>=1).
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw_slow  in  1  board switch, async; 1 selects SLOW_DIV, 0 selects FAST_DIV.
- sw_step  in  1  board switch, async; 1 selects single-step mode.
- btn_step  in  1  raw push button, async, active-high, bouncy.
- halt_req  in  1  CPU halt request, synchronous to clk, level.
- cpu_ce  out  1  CPU clock enable; one-cycle pulses.
- cycle_cnt  out  32  count of cpu_ce pulses issued.
- state  out  2  FSM state encoding: 0 RUN, 1 STEP_IDLE, 2 STEP_FIRE, 3 HALT.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - state = RUN; cpu_ce = 0; cycle_cnt = 0.
  - Divider counter = 0; all synchronizer and debounce flops = 0.
- Input conditioning:
  - sw_slow, sw_step and btn_step each pass through a 2-flop synchronizer.
  - Debounce: a counter runs while btn_sync differs from btn_db and clears when they match. When the counter reaches DB_CYCLES-1, btn_db takes btn_sync and the counter clears.
  - press is a one-cycle pulse on the rising edge of btn_db. Releases generate nothing.
- Divider (RUN only):
  - div_cnt counts 0..DIV-1 and wraps, where DIV = sw_slow_sync ? SLOW_DIV : FAST_DIV.
  - cpu_ce is registered high in the cycle after div_cnt == DIV-1, i.e. one pulse per DIV clocks. With DIV = 1, cpu_ce is continuously high.
  - A change of sw_slow_sync clears div_cnt; no pulse is issued in that cycle.
  - div_cnt is held at 0 in every state other than RUN.
- FSM transitions, evaluated each cycle in the priority order given:
  - Any state, halt_req = 1 -> HALT. This overrides a coincident pulse: cpu_ce is 0 in the cycle HALT is entered.
  - RUN: sw_step_sync = 1 -> STEP_IDLE. Otherwise stays in RUN and pulses per the divider.
  - STEP_IDLE: sw_step_sync = 0 -> RUN, with div_cnt starting at 0. Otherwise press -> STEP_FIRE.
  - STEP_FIRE: cpu_ce = 1 for exactly this one cycle, then -> STEP_IDLE unconditionally. A press arriving during STEP_FIRE is dropped.
  - HALT: cpu_ce = 0. If press and halt_req = 0, exit to STEP_IDLE when sw_step_sync = 1, otherwise to RUN. A press while halt_req is still 1 is ignored.
- cpu_ce is a registered decode of next state/divider, so it is glitch-free and aligned to the state output.
- cycle_cnt increments by 1 in every cycle with cpu_ce = 1 and wraps from 0xFFFFFFFF to 0 with no flag.
- Mid-operation reset: asserting rst_n low in any state immediately forces cpu_ce = 0, and all registers return to their reset values.
- Switch changes reach the FSM 2 clocks after the pin toggles; a button press reaches it 2 + DB_CYCLES clocks after the pin settles.

Test Plan:
Bench parameters: FAST_DIV=4, SLOW_DIV=16, DB_CYCLES=4.
1. Reset release with sw_slow=0, sw_step=0 -> first cpu_ce 4 clocks after rst_n rises, then period 4. After 10 pulses cycle_cnt = 10. Setting sw_slow=1 -> div_cnt restarts and the period becomes 16.
2. sw_step=1, then a clean button press held for 10 clocks -> exactly one cpu_ce, issued 2+4+1 clocks after the press; state sequence 1 -> 2 -> 1; cycle_cnt +1. A second press after release gives one further pulse.
3. Bouncy press (toggling every 2 clocks for 12 clocks, then held high) -> exactly one cpu_ce, and no pulse during the bounce.
4. halt_req=1 asserted in the same cycle div_cnt == 3 in RUN -> no cpu_ce, state = 3. A press while halt_req=1 is ignored. After halt_req drops, a press with sw_step=0 -> RUN, first pulse 4 clocks later.
5. Preload via a long run, or force cycle_cnt to 0xFFFFFFFE -> two pulses give 0xFFFFFFFF, then 0.
6. rst_n pulsed low in STEP_FIRE -> cpu_ce drops in the same cycle; state = 0 and cycle_cnt = 0.
